proj_fm_buf_ctrl: RTL and testbench
===================================

Name: proj_fm_buf_ctrl

Overview:
Sequencing controller for the multi-buffer feature-map RAM (proj_fm_ram).
- Accepts a producer word stream (valid/ready) and generates write addresses: buffer, RAM, entry, offset.
- Tracks per-buffer fill state and hands completed buffers to a consumer as READ_ADDRESSES_COUNT-wide read beats.
- Rotates write and read buffer indices round-robin, so the producer fills one buffer while the consumer drains another.

Parameters:
BUFFER_COUNT, 2, number of buffers; must be >=2.
RAMS, 2, RAM banks per buffer.
ENTRIES, 2, entries per RAM.
OFFSET, 2, words per entry.
READ_ADDRESSES_COUNT, 4, words returned per read beat; must divide DEPTH.
Derived constants:
- DEPTH = RAMS*ENTRIES*OFFSET words per buffer.
- BEATS = DEPTH/READ_ADDRESSES_COUNT read beats per buffer.
- Each index width is max(1, $clog2(N)).

Ports:
in_clk  input  1  clock
in_rst  input  1  asynchronous, active-high reset
in_flush  input  1  synchronous clear of all state, same effect as reset
in_wr_valid  input  1  producer word available
out_wr_ready  output  1  controller can accept a word
out_wr_en  output  1  write strobe to RAM (= in_wr_valid & out_wr_ready)
out_wr_buf  output  BUF_W  buffer being filled
out_wr_ram  output  RAM_W  RAM index of the current write
out_wr_entry  output  ENT_W  entry index of the current write
out_wr_offset  output  OFF_W  offset of the current write
out_rd_valid  output  1  a FULL buffer is available to read
in_rd_ready  input  1  consumer accepts a beat
out_rd_buf  output  BUF_W  buffer being drained
out_rd_beat  output  BEAT_W  beat index within the buffer
out_rd_last  output  1  current beat is BEATS-1
out_rd_data_valid  output  1  RAM read data valid; one cycle after a beat fires
out_full_count  output  $clog2(BUFFER_COUNT+1)  number of buffers in FULL state

Behaviour:
- Per-buffer state is an enum: FREE, FILLING, FULL. All state is registered.
- Reset, asserted asynchronously:
  - wr_idx=0, rd_idx=0, wr_cnt=0, beat_cnt=0.
  - All buffers FREE; out_rd_data_valid=0, out_full_count=0.
  - Resulting outputs: out_wr_ready=1, out_rd_valid=0, out_wr_en=0 (in_wr_valid low), all index outputs 0.
- in_flush produces the same state as reset on the next clock edge. Flush has priority over a write or read firing in the same cycle.
- Write side:
  - out_wr_ready = (state[wr_idx] != FULL). It is combinational from registered state.
  - Write fire = in_wr_valid & out_wr_ready. On fire, state[wr_idx] becomes FILLING (if it was FREE) and wr_cnt increments.
  - Address split of wr_cnt: offset = wr_cnt % OFFSET; entry = (wr_cnt/OFFSET) % ENTRIES; ram = wr_cnt/(OFFSET*ENTRIES).
  - The write on wr_cnt == DEPTH-1 sets state[wr_idx]=FULL, wr_cnt=0, and wr_idx=(wr_idx+1) mod BUFFER_COUNT.
  - Writes are back-to-back capable: one word per cycle, zero bubbles across buffer boundaries when the next buffer is FREE.
- Read side:
  - out_rd_valid = (state[rd_idx] == FULL). A buffer becomes readable the cycle after its last write.
  - Read fire = out_rd_valid & in_rd_ready. On fire, beat_cnt increments.
  - Firing at beat_cnt == BEATS-1 sets state[rd_idx]=FREE, beat_cnt=0, and rd_idx advances mod BUFFER_COUNT.
  - The freed buffer is writable from the next cycle.
  - out_rd_data_valid is the read fire delayed by one register, matching the 1-cycle RAM read latency.
  - out_rd_valid may only drop after a fire; the consumer may stall arbitrarily with no state change.
- Simultaneous events:
  - Last write into one buffer and last read of another in the same cycle: both transitions apply.
  - out_full_count updates by +1-1 = net 0.
  - The same buffer can never be both completing a fill and completing a drain in one cycle.
- All buffers FULL: out_wr_ready=0 and producer words are held (not dropped). There is no overflow error path.
- Wrap: wr_idx and rd_idx wrap BUFFER_COUNT-1 -> 0 (correct for non-power-of-two counts).
- Reset mid-operation: partially written buffers are discarded, and writing restarts at buffer 0, ram 0, entry 0, offset 0.

Decomposition:
- Package proj_fm_pkg holds:
  - the buf_state_e enum (FREE, FILLING, FULL);
  - a width function clog2_min1;
  - a DEPTH/BEATS derivation function.
- One sub-module, proj_fm_addr_split: a parameterised counter that produces ram/entry/offset plus a last flag, with in_clk, in_rst, clear, and increment inputs.
- The controller instantiates proj_fm_addr_split once on the write side; the read beat counter stays inline.

Test Plan (defaults: DEPTH=8, BEATS=2):
1. Reset, then 8 consecutive writes, in_rd_ready=0:
   - (ram,entry,offset) sequence is 000, 001, 010, 011, 100, 101, 110, 111, all with out_wr_buf=0.
   - The next cycle shows out_wr_buf=1, out_rd_valid=1, out_rd_buf=0, out_full_count=1.
2. 16 writes with no reads:
   - out_wr_ready=0 and out_full_count=2 after the 16th write.
   - A 17th word with in_wr_valid held high for 5 cycles produces no out_wr_en pulse.
3. Drain buffer 0 with in_rd_ready=1 for 2 cycles:
   - out_rd_beat goes 0, then 1; out_rd_last=1 on beat 1.
   - out_rd_data_valid pulses one cycle after each beat.
   - out_rd_buf=1 next, and out_wr_ready=1 the following cycle.
4. Simultaneous events, with buf0 FULL and buf1 holding 7 words: fire the 8th write and read beat 1 of buf0 in the same cycle.
   - Required result: buf0 FREE, buf1 FULL, wr_idx=0, rd_idx=1, out_full_count stays 1.
5. Assert in_rst asynchronously (mid-cycle) after 3 writes:
   - All outputs return to reset values immediately.
   - After release, the first write goes to buf 0, ram 0, entry 0, offset 0.
6. in_flush with both buffers FULL and in_rd_ready=1 in the same cycle: no beat is counted, and next cycle out_full_count=0, out_wr_ready=1.

Source files
------------

// File: rtl/proj_fm_pkg.sv
// Shared types and sizing helpers for the feature-map buffer controller.
// Buffer state encoding plus depth/beat derivation.
package proj_fm_pkg;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    FULL
  } buf_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int fm_depth(input int rams,
                                  input int entries,
                                  input int offset);
    return rams * entries * offset;
  endfunction

  function automatic int fm_beats(input int depth,
                                  input int rd_cnt);
    return depth / rd_cnt;
  endfunction

endpackage

// File: rtl/proj_fm_buf_ctrl_if.sv
// Producer/consumer handshake and address bundle of the buffer controller.
// slave is the controller side, master the producer/consumer side.
interface proj_fm_buf_ctrl_if
  import proj_fm_pkg::*;
#(
  parameter int BUFFER_COUNT         = 2,
  parameter int RAMS                 = 2,
  parameter int ENTRIES              = 2,
  parameter int OFFSET               = 2,
  parameter int READ_ADDRESSES_COUNT = 4
) ();

  localparam int DEPTH  = fm_depth(RAMS, ENTRIES, OFFSET);
  localparam int BEATS  = fm_beats(DEPTH, READ_ADDRESSES_COUNT);
  localparam int BUF_W  = clog2_min1(BUFFER_COUNT);
  localparam int RAM_W  = clog2_min1(RAMS);
  localparam int ENT_W  = clog2_min1(ENTRIES);
  localparam int OFF_W  = clog2_min1(OFFSET);
  localparam int BEAT_W = clog2_min1(BEATS);
  localparam int CNT_W  = clog2_min1(BUFFER_COUNT + 1);

  logic              in_wr_valid;
  logic              out_wr_ready;
  logic              out_wr_en;
  logic [BUF_W-1:0]  out_wr_buf;
  logic [RAM_W-1:0]  out_wr_ram;
  logic [ENT_W-1:0]  out_wr_entry;
  logic [OFF_W-1:0]  out_wr_offset;
  logic              out_rd_valid;
  logic              in_rd_ready;
  logic [BUF_W-1:0]  out_rd_buf;
  logic [BEAT_W-1:0] out_rd_beat;
  logic              out_rd_last;
  logic              out_rd_data_valid;
  logic [CNT_W-1:0]  out_full_count;

  modport slave (
    input  in_wr_valid,
    input  in_rd_ready,
    output out_wr_ready,
    output out_wr_en,
    output out_wr_buf,
    output out_wr_ram,
    output out_wr_entry,
    output out_wr_offset,
    output out_rd_valid,
    output out_rd_buf,
    output out_rd_beat,
    output out_rd_last,
    output out_rd_data_valid,
    output out_full_count
  );

  modport master (
    output in_wr_valid,
    output in_rd_ready,
    input  out_wr_ready,
    input  out_wr_en,
    input  out_wr_buf,
    input  out_wr_ram,
    input  out_wr_entry,
    input  out_wr_offset,
    input  out_rd_valid,
    input  out_rd_buf,
    input  out_rd_beat,
    input  out_rd_last,
    input  out_rd_data_valid,
    input  out_full_count
  );

endinterface

// File: rtl/proj_fm_addr_split.sv
// Write-word counter split into ram/entry/offset fields.
// Nested counters avoid dividers for non-power-of-two geometries.
module proj_fm_addr_split
  import proj_fm_pkg::*;
#(
  parameter int RAMS    = 2,
  parameter int ENTRIES = 2,
  parameter int OFFSET  = 2,
  parameter int RAM_W   = clog2_min1(RAMS),
  parameter int ENT_W   = clog2_min1(ENTRIES),
  parameter int OFF_W   = clog2_min1(OFFSET)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             clear,
  input  logic             inc,
  output logic [RAM_W-1:0] ram,
  output logic [ENT_W-1:0] entry,
  output logic [OFF_W-1:0] offset,
  output logic             last
);

  logic off_last;
  logic ent_last;
  logic ram_last;

  assign off_last = (offset == OFF_W'(OFFSET - 1));
  assign ent_last = (entry == ENT_W'(ENTRIES - 1));
  assign ram_last = (ram == RAM_W'(RAMS - 1));
  assign last     = off_last & ent_last & ram_last;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      ram    <= '0;
      entry  <= '0;
      offset <= '0;
    end else if (clear) begin
      ram    <= '0;
      entry  <= '0;
      offset <= '0;
    end else if (inc) begin
      offset <= off_last ? '0 : offset + OFF_W'(1);
      if (off_last) begin
        entry <= ent_last ? '0 : entry + ENT_W'(1);
        if (ent_last)
          ram <= ram_last ? '0 : ram + RAM_W'(1);
      end
    end
  end

endmodule

// File: rtl/proj_fm_buf_ctrl.sv
// Round-robin fill/drain sequencer for the multi-buffer feature-map RAM.
// Producer fills wr_idx while the consumer drains rd_idx in beats.
module proj_fm_buf_ctrl
  import proj_fm_pkg::*;
#(
  parameter int BUFFER_COUNT         = 2,
  parameter int RAMS                 = 2,
  parameter int ENTRIES              = 2,
  parameter int OFFSET               = 2,
  parameter int READ_ADDRESSES_COUNT = 4
) (
  input logic               in_clk,
  input logic               in_rst,
  input logic               in_flush,
  proj_fm_buf_ctrl_if.slave bus
);

  localparam int DEPTH  = fm_depth(RAMS, ENTRIES, OFFSET);
  localparam int BEATS  = fm_beats(DEPTH, READ_ADDRESSES_COUNT);
  localparam int BUF_W  = clog2_min1(BUFFER_COUNT);
  localparam int BEAT_W = clog2_min1(BEATS);
  localparam int CNT_W  = clog2_min1(BUFFER_COUNT + 1);

  buf_state_e        state_q [BUFFER_COUNT];
  buf_state_e        state_d [BUFFER_COUNT];
  logic [BUF_W-1:0]  wr_idx;
  logic [BUF_W-1:0]  rd_idx;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CNT_W-1:0]  full_cnt;
  logic              rd_dv;

  logic wr_ready;
  logic wr_fire;
  logic wr_last;
  logic wr_done;
  logic rd_valid;
  logic rd_fire;
  logic rd_last;
  logic rd_done;

  function automatic logic [BUF_W-1:0] nxt_idx(
    input logic [BUF_W-1:0] i
  );
    return (i == BUF_W'(BUFFER_COUNT - 1)) ? '0 : i + BUF_W'(1);
  endfunction

  assign wr_ready = (state_q[wr_idx] != FULL);
  assign wr_fire  = bus.in_wr_valid & wr_ready;
  assign wr_done  = wr_fire & wr_last;
  assign rd_valid = (state_q[rd_idx] == FULL);
  assign rd_fire  = rd_valid & bus.in_rd_ready;
  assign rd_last  = (beat_cnt == BEAT_W'(BEATS - 1));
  assign rd_done  = rd_fire & rd_last;

  // Flush clears the write counter alongside the buffer state.
  proj_fm_addr_split #(
    .RAMS    (RAMS),
    .ENTRIES (ENTRIES),
    .OFFSET  (OFFSET)
  ) u_wr_split (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .clear  (in_flush),
    .inc    (wr_fire),
    .ram    (bus.out_wr_ram),
    .entry  (bus.out_wr_entry),
    .offset (bus.out_wr_offset),
    .last   (wr_last)
  );

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < BUFFER_COUNT; i++) begin
      if (wr_fire && wr_idx == BUF_W'(i))
        state_d[i] = wr_last ? FULL : FILLING;
      if (rd_done && rd_idx == BUF_W'(i))
        state_d[i] = FREE;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < BUFFER_COUNT; i++)
        state_q[i] <= FREE;
    end else if (in_flush) begin
      for (int i = 0; i < BUFFER_COUNT; i++)
        state_q[i] <= FREE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      beat_cnt <= '0;
      full_cnt <= '0;
      rd_dv    <= 1'b0;
    end else if (in_flush) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      beat_cnt <= '0;
      full_cnt <= '0;
      rd_dv    <= 1'b0;
    end else begin
      rd_dv    <= rd_fire;
      full_cnt <= full_cnt + CNT_W'(wr_done) - CNT_W'(rd_done);
      if (wr_done)
        wr_idx <= nxt_idx(wr_idx);
      if (rd_fire)
        beat_cnt <= rd_last ? '0 : beat_cnt + BEAT_W'(1);
      if (rd_done)
        rd_idx <= nxt_idx(rd_idx);
    end
  end

  assign bus.out_wr_ready      = wr_ready;
  assign bus.out_wr_en         = wr_fire;
  assign bus.out_wr_buf        = wr_idx;
  assign bus.out_rd_valid      = rd_valid;
  assign bus.out_rd_buf        = rd_idx;
  assign bus.out_rd_beat       = beat_cnt;
  assign bus.out_rd_last       = rd_last;
  assign bus.out_rd_data_valid = rd_dv;
  assign bus.out_full_count    = full_cnt;

endmodule

// File: tb/tb_proj_fm_buf_ctrl.sv
// Directed bench for proj_fm_buf_ctrl at default geometry.
// DEPTH=8, BEATS=2, two buffers.
module tb_proj_fm_buf_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  proj_fm_buf_ctrl_if bus ();

  proj_fm_buf_ctrl dut (
    .in_clk   (clk),
    .in_rst   (rst),
    .in_flush (flush),
    .bus      (bus.slave)
  );

  int n_chk = 0;
  int n_ok  = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp)
      n_ok++;
    else
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    edge1();
    edge1();
    rst = 1'b0;
  endtask

  function automatic int addr();
    return int'({bus.out_wr_ram, bus.out_wr_entry, bus.out_wr_offset});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    bus.in_wr_valid = 1'b0;
    bus.in_rd_ready = 1'b0;
    do_reset();
    #1;
    chk("rst_wr_ready", bus.out_wr_ready, 1);
    chk("rst_rd_valid", bus.out_rd_valid, 0);
    chk("rst_wr_en", bus.out_wr_en, 0);
    chk("rst_full", bus.out_full_count, 0);
    chk("rst_wr_buf", bus.out_wr_buf, 0);
    chk("rst_addr", addr(), 0);
    chk("rst_rd_dv", bus.out_rd_data_valid, 0);

    // fill buffer 0 word by word
    bus.in_wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t1_addr", addr(), i);
      chk("t1_wr_buf", bus.out_wr_buf, 0);
      chk("t1_wr_en", bus.out_wr_en, 1);
      edge1();
    end
    bus.in_wr_valid = 1'b0;
    #1;
    chk("t1_wr_buf_next", bus.out_wr_buf, 1);
    chk("t1_rd_valid", bus.out_rd_valid, 1);
    chk("t1_rd_buf", bus.out_rd_buf, 0);
    chk("t1_full", bus.out_full_count, 1);

    bus.in_wr_valid = 1'b1;
    repeat (8) edge1();
    bus.in_wr_valid = 1'b0;
    #1;
    chk("t2_wr_ready", bus.out_wr_ready, 0);
    chk("t2_full", bus.out_full_count, 2);
    bus.in_wr_valid = 1'b1;
    repeat (5) begin
      #1;
      chk("t2_hold_wr_en", bus.out_wr_en, 0);
      edge1();
    end
    bus.in_wr_valid = 1'b0;

    bus.in_rd_ready = 1'b1;
    #1;
    chk("t3_beat0", bus.out_rd_beat, 0);
    chk("t3_last0", bus.out_rd_last, 0);
    chk("t3_dv0", bus.out_rd_data_valid, 0);
    edge1();
    chk("t3_beat1", bus.out_rd_beat, 1);
    chk("t3_last1", bus.out_rd_last, 1);
    chk("t3_dv1", bus.out_rd_data_valid, 1);
    edge1();
    bus.in_rd_ready = 1'b0;
    #1;
    chk("t3_rd_buf", bus.out_rd_buf, 1);
    chk("t3_dv2", bus.out_rd_data_valid, 1);
    chk("t3_wr_ready", bus.out_wr_ready, 1);
    chk("t3_full", bus.out_full_count, 1);
    edge1();
    chk("t3_dv3", bus.out_rd_data_valid, 0);

    // buf0 full, buf1 holds 7 words, beat 0 of buf0 already read
    do_reset();
    bus.in_wr_valid = 1'b1;
    repeat (15) edge1();
    bus.in_wr_valid = 1'b0;
    bus.in_rd_ready = 1'b1;
    #1;
    chk("t4_beat0", bus.out_rd_beat, 0);
    edge1();
    bus.in_wr_valid = 1'b1;
    #1;
    chk("t4_addr", addr(), 7);
    chk("t4_wr_buf", bus.out_wr_buf, 1);
    chk("t4_wr_en", bus.out_wr_en, 1);
    chk("t4_last", bus.out_rd_last, 1);
    edge1();
    bus.in_wr_valid = 1'b0;
    bus.in_rd_ready = 1'b0;
    #1;
    chk("t4_full", bus.out_full_count, 1);
    chk("t4_wr_buf_next", bus.out_wr_buf, 0);
    chk("t4_rd_buf", bus.out_rd_buf, 1);
    chk("t4_rd_valid", bus.out_rd_valid, 1);
    chk("t4_wr_ready", bus.out_wr_ready, 1);

    // asynchronous reset mid-cycle
    do_reset();
    bus.in_wr_valid = 1'b1;
    repeat (11) edge1();
    bus.in_wr_valid = 1'b0;
    #1;
    chk("t5_pre_addr", addr(), 3);
    chk("t5_pre_buf", bus.out_wr_buf, 1);
    chk("t5_pre_full", bus.out_full_count, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_addr", addr(), 0);
    chk("t5_wr_buf", bus.out_wr_buf, 0);
    chk("t5_wr_ready", bus.out_wr_ready, 1);
    chk("t5_full", bus.out_full_count, 0);
    chk("t5_rd_valid", bus.out_rd_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_wr_valid = 1'b1;
    #1;
    chk("t5_first_addr", addr(), 0);
    chk("t5_first_buf", bus.out_wr_buf, 0);
    chk("t5_first_en", bus.out_wr_en, 1);
    edge1();
    bus.in_wr_valid = 1'b0;
    #1;
    chk("t5_second_addr", addr(), 1);

    // flush beats a simultaneous read fire
    do_reset();
    bus.in_wr_valid = 1'b1;
    repeat (16) edge1();
    bus.in_wr_valid = 1'b0;
    #1;
    chk("t6_pre_full", bus.out_full_count, 2);
    flush = 1'b1;
    bus.in_rd_ready = 1'b1;
    edge1();
    flush = 1'b0;
    bus.in_rd_ready = 1'b0;
    #1;
    chk("t6_full", bus.out_full_count, 0);
    chk("t6_wr_ready", bus.out_wr_ready, 1);
    chk("t6_rd_valid", bus.out_rd_valid, 0);
    chk("t6_dv", bus.out_rd_data_valid, 0);
    chk("t6_beat", bus.out_rd_beat, 0);
    chk("t6_wr_buf", bus.out_wr_buf, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
